uart_tx_cfg: RTL and testbench

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_tx_cfg.sv | 146 ++++++++++++++
 tb/tb_uart_tx_cfg.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and default parameters for the configurable UART transmitter.
// UART_TX_PARITY_EN adds the PARITY state to the FSM encoding.
package uart_pkg;

  localparam int unsigned NB_DEFAULT           = 8;
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 87;
  localparam int unsigned STOP_BITS_DEFAULT    = 1;
  localparam int unsigned PARITY_ODD_DEFAULT   = 0;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} tx_state_e;
`endif

endpackage

// File: rtl/uart_baud_tick.sv
// Bit timer: down-counter that flags the last cycle of each bit and restarts on start.
import uart_pkg::*;

module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic tick_c
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt;

  // Reload on restart or at bit end so consecutive bits run without a stall cycle.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (start || (cnt == '0))
      cnt <= CW'(CLKS_PER_BIT - 1);
    else
      cnt <= cnt - CW'(1);
  end

  assign tick_c = (cnt == '0);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: NB data bits LSB first, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to insert a parity bit (PARITY_ODD selects odd parity).
import uart_pkg::*;

module uart_tx_cfg #(
  parameter int unsigned NB           = NB_DEFAULT,
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned STOP_BITS    = STOP_BITS_DEFAULT,
  parameter int unsigned PARITY_ODD   = PARITY_ODD_DEFAULT
) (
  input  logic          i_Clock,
  input  logic          i_Reset,
  input  logic          i_Tx_DV,
  input  logic [NB-1:0] i_Tx_Byte,
  output logic          o_Tx_Ready,
  output logic          o_Tx_Active,
  output logic          o_Tx_Serial,
  output logic          o_Tx_Reload,
  output logic          o_Tx_Done
);

  localparam int unsigned IW = $clog2(NB);

  tx_state_e     state_q, state_d;
  logic [NB-1:0] data_q, data_d;
  logic [IW-1:0] idx_q, idx_d, idx_inc;
  logic          stop_q, stop_d;
  logic          serial_d, ready_d, active_d, reload_d, done_d;
  logic          start_c, tick_c;

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk    (i_Clock),
    .rst    (i_Reset),
    .start  (start_c),
    .tick_c (tick_c)
  );

  // Next-state and next-output logic; every output is computed one cycle ahead.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    idx_d    = idx_q;
    stop_d   = stop_q;
    serial_d = o_Tx_Serial;
    ready_d  = 1'b0;
    active_d = 1'b1;
    reload_d = 1'b0;
    done_d   = 1'b0;
    start_c  = 1'b0;
    idx_inc  = idx_q + IW'(1);
    case (state_q)
      IDLE: begin
        ready_d  = 1'b1;
        active_d = 1'b0;
        serial_d = 1'b1;
        if (i_Tx_DV) begin
          state_d  = START;
          data_d   = i_Tx_Byte;
          idx_d    = '0;
          serial_d = 1'b0;
          ready_d  = 1'b0;
          active_d = 1'b1;
          start_c  = 1'b1;
        end
      end
      START: begin
        if (tick_c) begin
          state_d  = DATA;
          idx_d    = '0;
          serial_d = data_q[0];
        end
      end
      DATA: begin
        if (tick_c) begin
          if (idx_q == IW'(NB - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d  = PARITY;
            serial_d = (^data_q) ^ 1'(PARITY_ODD);
`else
            state_d  = STOP;
            serial_d = 1'b1;
            stop_d   = 1'b0;
`endif
          end else begin
            idx_d    = idx_inc;
            serial_d = data_q[idx_inc];
            reload_d = (idx_inc == IW'(NB - 1));
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick_c) begin
          state_d  = STOP;
          serial_d = 1'b1;
          stop_d   = 1'b0;
        end
      end
`endif
      STOP: begin
        serial_d = 1'b1;
        if (tick_c) begin
          if (stop_q == 1'(STOP_BITS - 1)) begin
            state_d  = IDLE;
            done_d   = 1'b1;
            ready_d  = 1'b1;
            active_d = 1'b0;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        serial_d = 1'b1;
        ready_d  = 1'b1;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q     <= IDLE;
      data_q      <= '0;
      idx_q       <= '0;
      stop_q      <= 1'b0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Ready  <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Reload <= 1'b0;
      o_Tx_Done   <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      idx_q       <= idx_d;
      stop_q      <= stop_d;
      o_Tx_Serial <= serial_d;
      o_Tx_Ready  <= ready_d;
      o_Tx_Active <= active_d;
      o_Tx_Reload <= reload_d;
      o_Tx_Done   <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: an 8-bit/4-clock instance and a 12-bit/1-clock
// two-stop-bit odd-parity instance; parity expectations follow UART_TX_PARITY_EN.
module tb_uart_tx_cfg;

  logic        clk;
  logic        rst;
  logic        dv1, s1, rdy1, act1, rl1, dn1;
  logic [7:0]  byte1;
  logic        dv2, s2, rdy2, act2, rl2, dn2;
  logic [11:0] byte2;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef UART_TX_PARITY_EN
  localparam int L2 = 16;
`else
  localparam int L2 = 15;
`endif

  uart_tx_cfg #(.NB(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_ODD(0)) dut1 (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv1), .i_Tx_Byte(byte1),
    .o_Tx_Ready(rdy1), .o_Tx_Active(act1), .o_Tx_Serial(s1),
    .o_Tx_Reload(rl1), .o_Tx_Done(dn1)
  );

  uart_tx_cfg #(.NB(12), .CLKS_PER_BIT(1), .STOP_BITS(2), .PARITY_ODD(1)) dut2 (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv2), .i_Tx_Byte(byte2),
    .o_Tx_Ready(rdy2), .o_Tx_Active(act2), .o_Tx_Serial(s2),
    .o_Tx_Reload(rl2), .o_Tx_Done(dn2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One 8-bit frame; k counts negedges after the acceptance edge. poke_k injects a stray request.
  task automatic frame1(input logic [7:0] w, input int poke_k, input logic [7:0] poke_w,
                        input string tag);
    logic [9:0] fr;
    int bad, nrl, rl_at, ndn, dn_at;
    fr = {1'b1, w, 1'b0};
    bad = 0; nrl = 0; rl_at = -1; ndn = 0; dn_at = -1;
    @(negedge clk);
    dv1 = 1'b1; byte1 = w;
    @(negedge clk);
    dv1 = 1'b0;
    for (int k = 0; k < 48; k++) begin
      if (k < 40) begin
        if (s1 !== fr[k/4]) bad++;
      end else if (s1 !== 1'b1) bad++;
      if (rl1) begin nrl++; rl_at = k; end
      if (dn1) begin ndn++; dn_at = k; end
      if (k == 0) begin
        check({tag, " ready_low"}, 64'(rdy1), 64'd0);
        check({tag, " active_high"}, 64'(act1), 64'd1);
      end
      if (k == 39) check({tag, " active_last"}, 64'(act1), 64'd1);
      if (k == 40) begin
        check({tag, " active_fall"}, 64'(act1), 64'd0);
        check({tag, " ready_rise"}, 64'(rdy1), 64'd1);
      end
      if (k == poke_k) begin dv1 = 1'b1; byte1 = poke_w; end
      @(negedge clk);
      dv1 = 1'b0;
    end
    check({tag, " serial_errs"}, 64'(bad), 64'd0);
    check({tag, " done_count"}, 64'(ndn), 64'd1);
    check({tag, " done_cycle"}, 64'(dn_at), 64'd40);
    check({tag, " reload_count"}, 64'(nrl), 64'd1);
    check({tag, " reload_cycle"}, 64'(rl_at), 64'd32);
  endtask

  // One 12-bit frame on dut2; b2b requests the next word in the done cycle.
  task automatic frame2(input logic [11:0] w, input bit send, input bit b2b,
                        input logic [11:0] w_next, input string tag);
    logic [15:0] fr;
    logic par;
    int bad, nrl, rl_at, ndn, dn_at, kmax;
    fr = '1;
    fr[0] = 1'b0;
    for (int i = 0; i < 12; i++) fr[1+i] = w[i];
    par = 1'bx;
    bad = 0; nrl = 0; rl_at = -1; ndn = 0; dn_at = -1;
    kmax = b2b ? L2 : L2 + 3;
    if (send) begin
      @(negedge clk);
      dv2 = 1'b1; byte2 = w;
      @(negedge clk);
      dv2 = 1'b0;
    end
    for (int k = 0; k <= kmax; k++) begin
      if (k < L2) begin
`ifdef UART_TX_PARITY_EN
        if (k == 13) par = s2;
        else if (s2 !== fr[k]) bad++;
`else
        if (s2 !== fr[k]) bad++;
`endif
      end else if (s2 !== 1'b1) bad++;
      if (rl2) begin nrl++; rl_at = k; end
      if (dn2) begin ndn++; dn_at = k; end
      if (k == L2) check({tag, " ready_at_done"}, 64'(rdy2), 64'd1);
      if (k == L2 && b2b) begin dv2 = 1'b1; byte2 = w_next; end
      @(negedge clk);
      dv2 = 1'b0;
    end
    if (b2b) begin
      check({tag, " b2b_start"}, 64'(s2), 64'd0);
      check({tag, " b2b_active"}, 64'(act2), 64'd1);
    end
    check({tag, " serial_errs"}, 64'(bad), 64'd0);
    check({tag, " done_count"}, 64'(ndn), 64'd1);
    check({tag, " done_cycle"}, 64'(dn_at), 64'(L2));
    check({tag, " reload_count"}, 64'(nrl), 64'd1);
    check({tag, " reload_cycle"}, 64'(rl_at), 64'd12);
`ifdef UART_TX_PARITY_EN
    check({tag, " parity"}, 64'(par), 64'(~^w));
`endif
  endtask

  initial begin
    int ndn;
    rst = 1'b1; dv1 = 1'b0; byte1 = '0; dv2 = 1'b0; byte2 = '0;
    repeat (3) @(negedge clk);
    check("rst serial1", 64'(s1), 64'd1);
    check("rst ready1", 64'(rdy1), 64'd1);
    check("rst active1", 64'(act1), 64'd0);
    check("rst reload1", 64'(rl1), 64'd0);
    check("rst done1", 64'(dn1), 64'd0);
    check("rst serial2", 64'(s2), 64'd1);
    check("rst ready2", 64'(rdy2), 64'd1);
    check("rst active2", 64'(act2), 64'd0);

    // Request during reset must be dropped.
    dv1 = 1'b1; byte1 = 8'hFF;
    @(negedge clk);
    dv1 = 1'b0;
    check("rst_prio serial", 64'(s1), 64'd1);
    check("rst_prio active", 64'(act1), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle serial", 64'(s1), 64'd1);

    frame1(8'hA5, -1, 8'h00, "a5");
    frame1(8'h3C, 14, 8'hFF, "ignore_dv");

    // Reset during data bit 3 (frame cycles 16..19).
    @(negedge clk);
    dv1 = 1'b1; byte1 = 8'h5A;
    @(negedge clk);
    dv1 = 1'b0;
    repeat (17) @(negedge clk);
    check("midrst active_before", 64'(act1), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst serial", 64'(s1), 64'd1);
    check("midrst ready", 64'(rdy1), 64'd1);
    check("midrst active", 64'(act1), 64'd0);
    ndn = 0;
    for (int i = 0; i < 3; i++) begin
      if (dn1) ndn++;
      @(negedge clk);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (dn1) ndn++;
      @(negedge clk);
    end
    check("midrst no_done", 64'(ndn), 64'd0);
    frame1(8'h81, -1, 8'h00, "after_rst");

    frame2(12'h00F, 1'b1, 1'b0, 12'h000, "w00f");
    frame2(12'hA5C, 1'b1, 1'b1, 12'h5A3, "b2b_first");
    frame2(12'h5A3, 1'b0, 1'b0, 12'h000, "b2b_second");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
